// File: rtl/wallace_pkg.sv
// Shared sizes and partial-product row construction for the 8x8 Wallace reduction.
// The signed (Baugh-Wooley) row form is selected by the caller, see WALLACE_SIGNED_EN in the top.
package wallace_pkg;

  localparam int OP_W      = 8;
  localparam int PROD_W    = 16;
  localparam int N_PP_ROWS = 8;
  localparam int S1_ROWS   = 4;

  // Row i of the partial-product array, already shifted to weight i.
  // Baugh-Wooley: the two Baugh-Wooley constants (weights 8 and 15) land in free bit
  // positions of rows 0 and 7, so the array stays at exactly eight rows.
  function automatic logic [PROD_W-1:0] pp_row(
    input logic [OP_W-1:0] a,
    input logic [OP_W-1:0] b,
    input int              i,
    input bit              signed_en
  );
    logic [PROD_W-1:0] row;
    logic              bit_v;
    row = '0;
    for (int j = 0; j < OP_W; j++) begin
      bit_v = a[j] & b[i];
      if (signed_en && ((i == OP_W-1) != (j == OP_W-1))) begin
        bit_v = ~bit_v;
      end
      row[i+j] = bit_v;
    end
    if (signed_en && (i == 0)) begin
      row[OP_W] = 1'b1;
    end
    if (signed_en && (i == OP_W-1)) begin
      row[PROD_W-1] = 1'b1;
    end
    return row;
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// One carry-save layer: a row of full adders reducing three rows to a sum row and a
// carry row pre-shifted by one, with the carry out of the top bit dropped.
module csa_3to2
  import wallace_pkg::*;
#(
  parameter int W = PROD_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  logic [W-2:0] maj;

  assign s   = x ^ y ^ z;
  assign maj = (x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]);
  assign c   = {maj, 1'b0};

endmodule

// File: rtl/wallace_reduce_8x8.sv
// Two-stage pipelined 8x8 Wallace reduction to a sum/carry row pair (mod 2^16).
// Define WALLACE_SIGNED_EN for two's-complement operands (Baugh-Wooley).
module wallace_reduce_8x8
  import wallace_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_s,
  output logic [PROD_W-1:0] out_c,
  output logic [TAG_W-1:0]  out_tag
);

`ifdef WALLACE_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic [PROD_W-1:0] pp [N_PP_ROWS];

  always_comb begin
    for (int i = 0; i < N_PP_ROWS; i++) begin
      pp[i] = pp_row(in_a, in_b, i, SIGNED_EN);
    end
  end

  // Stage 1: 8 -> 6 -> 4
  logic [PROD_W-1:0] l1a_s, l1a_c, l1b_s, l1b_c;
  logic [PROD_W-1:0] l2a_s, l2a_c, l2b_s, l2b_c;

  csa_3to2 #(.W(PROD_W)) u_l1a (.x(pp[0]), .y(pp[1]), .z(pp[2]), .s(l1a_s), .c(l1a_c));
  csa_3to2 #(.W(PROD_W)) u_l1b (.x(pp[3]), .y(pp[4]), .z(pp[5]), .s(l1b_s), .c(l1b_c));
  csa_3to2 #(.W(PROD_W)) u_l2a (.x(l1a_s), .y(l1a_c), .z(l1b_s), .s(l2a_s), .c(l2a_c));
  csa_3to2 #(.W(PROD_W)) u_l2b (.x(l1b_c), .y(pp[6]), .z(pp[7]), .s(l2b_s), .c(l2b_c));

  logic [S1_ROWS-1:0][PROD_W-1:0] s1_rows_q, s1_rows_d;
  logic [TAG_W-1:0]               s1_tag_q, s1_tag_d;
  logic                           s1_valid_q, s1_valid_d;

  // Stage 2: 4 -> 3 -> 2
  logic [PROD_W-1:0] l3_s, l3_c, l4_s, l4_c;

  csa_3to2 #(.W(PROD_W)) u_l3 (
    .x(s1_rows_q[0]), .y(s1_rows_q[1]), .z(s1_rows_q[2]), .s(l3_s), .c(l3_c)
  );
  csa_3to2 #(.W(PROD_W)) u_l4 (
    .x(l3_s), .y(l3_c), .z(s1_rows_q[3]), .s(l4_s), .c(l4_c)
  );

  logic [PROD_W-1:0] out_s_q, out_s_d;
  logic [PROD_W-1:0] out_c_q, out_c_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
  logic              out_valid_q, out_valid_d;

  logic s2_adv, s1_adv, accept;

  always_comb begin
    s2_adv   = !out_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv && rst_n;
    accept   = in_valid && in_ready;

    s1_rows_d   = s1_rows_q;
    s1_tag_d    = s1_tag_q;
    s1_valid_d  = s1_valid_q;
    out_s_d     = out_s_q;
    out_c_d     = out_c_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q;

    if (s1_adv) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      s1_rows_d = {l2b_c, l2b_s, l2a_c, l2a_s};
      s1_tag_d  = in_tag;
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
    end
    if (s2_adv && s1_valid_q) begin
      out_s_d   = l4_s;
      out_c_d   = l4_c;
      out_tag_d = s1_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_rows_q   <= '0;
      s1_tag_q    <= '0;
      s1_valid_q  <= 1'b0;
      out_s_q     <= '0;
      out_c_q     <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_rows_q   <= s1_rows_d;
      s1_tag_q    <= s1_tag_d;
      s1_valid_q  <= s1_valid_d;
      out_s_q     <= out_s_d;
      out_c_q     <= out_c_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_s     = out_s_q;
  assign out_c     = out_c_q;
  assign out_tag   = out_tag_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_wallace_reduce_8x8.sv
// Scoreboard bench for wallace_reduce_8x8: accepted ops queue their expected product,
// a monitor pops and checks every output transfer. Honours WALLACE_SIGNED_EN.
module tb_wallace_reduce_8x8;

`ifdef WALLACE_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  tag;
    logic [15:0] prod;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a, in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_s, out_c;
  logic [3:0]  out_tag;

  int checks  = 0;
  int errors  = 0;
  int acc_cnt = 0;
  int out_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  wallace_reduce_8x8 #(.TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_c(out_c), .out_tag(out_tag)
  );

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
    int pa, pb;
    pa = SIGNED_EN ? int'($signed(a)) : int'(a);
    pb = SIGNED_EN ? int'($signed(b)) : int'(b);
    return 16'(pa * pb);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Input side of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      sb.push_back('{tag: in_tag, prod: model(in_a, in_b)});
      acc_cnt++;
    end
  end

  // Output side of the scoreboard.
  always @(negedge clk) begin
    logic [15:0] sum;
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      out_cnt++;
      sum = out_s + out_c;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output sum=%0h tag=%0h required=no output", sum, out_tag);
      end else begin
        e = sb.pop_front();
        if (sum !== e.prod || out_tag !== e.tag) begin
          errors++;
          $display("FAIL result sum=%0h tag=%0h required sum=%0h tag=%0h",
                   sum, out_tag, e.prod, e.tag);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t,
                         output int waits);
    bit got;
    got = 1'b0;
    waits = 0;
    in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
    while (!got && waits < 50) begin
      @(negedge clk);
      got = in_ready;
      step();
      if (!got) waits++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=no accept required=accept within 50 cycles");
    end
  endtask

  task automatic wait_out(input string name, input logic [15:0] req_sum, input logic [3:0] req_tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no out_valid required=out_valid", name);
    end else begin
      chk({name, "_sum"}, 32'(16'(out_s + out_c)), 32'(req_sum));
      chk({name, "_tag"}, 32'(out_tag), 32'(req_tag));
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, stalls, out0, acc0, bp_acc;
    bit got;
    logic [15:0] rec_s, rec_c;
    logic [3:0]  rec_t;

    rst_n = 1'b0; in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; in_tag = 4'h0; out_ready = 1'b1;

    // Reset held with in_valid asserted.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_s", 32'(out_s), 32'd0);
      chk("rst_out_c", 32'(out_c), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
    end
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    step();

    // Single op with exact latency.
    in_a = 8'hFF; in_b = 8'hFF; in_tag = 4'd3; in_valid = 1'b1;
    @(negedge clk);
    chk("single_accept", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("single_lat_early", 32'(out_valid), 32'd0);
    step();
    chk("single_lat_valid", 32'(out_valid), 32'd1);
    chk("single_sum", 32'(16'(out_s + out_c)), SIGNED_EN ? 32'h0001 : 32'hFE01);
    chk("single_tag", 32'(out_tag), 32'd3);
    step();
    step();

    // Directed signedness corners.
    send_op(8'h80, 8'hFF, 4'd5, w);
    in_valid = 1'b0;
    wait_out("signed_80xff", SIGNED_EN ? 16'h0080 : 16'h7F80, 4'd5);
    send_op(8'h7F, 8'h7F, 4'd6, w);
    in_valid = 1'b0;
    wait_out("signed_7fx7f", 16'h3F01, 4'd6);
    repeat (2) step();

    // Back-to-back random stream.
    stalls = 0;
    out0 = out_cnt;
    for (int n = 0; n < 256; n++) begin
      send_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'(n), w);
      stalls += w;
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk("stream_stalls", 32'(stalls), 32'd0);
    chk("stream_results", 32'(out_cnt - out0), 32'd256);

    // Backpressure: exactly two ops fit, outputs hold.
    out_ready = 1'b0;
    acc0 = acc_cnt;
    out0 = out_cnt;
    in_a = 8'($urandom_range(0, 255)); in_b = 8'($urandom_range(0, 255));
    in_tag = 4'h0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      got = in_ready;
      if (k == 2) begin
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        rec_s = out_s; rec_c = out_c; rec_t = out_tag;
      end
      if (k > 2) begin
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_s", 32'(out_s), 32'(rec_s));
        chk("bp_hold_c", 32'(out_c), 32'(rec_c));
        chk("bp_hold_tag", 32'(out_tag), 32'(rec_t));
      end
      step();
      if (got) begin
        in_a = 8'($urandom_range(0, 255)); in_b = 8'($urandom_range(0, 255));
        in_tag = in_tag + 4'd1;
      end
    end
    bp_acc = acc_cnt - acc0;
    chk("bp_accepted", 32'(bp_acc), 32'd2);
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    step();

    // Release: pending op plus a few more drain in order.
    out_ready = 1'b1;
    send_op(in_a, in_b, in_tag, w);
    for (int n = 0; n < 3; n++) begin
      send_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'(4'd8 + 4'(n)), w);
    end
    in_valid = 1'b0;
    repeat (5) step();
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_count", 32'(out_cnt - out0), 32'(acc_cnt - acc0));

    // Mid-flight reset with a full pipe.
    out_ready = 1'b0;
    send_op(8'h11, 8'h22, 4'hA, w);
    send_op(8'h33, 8'h44, 4'hB, w);
    in_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
      step();
    end

    // Recovery after reset.
    send_op(8'hC3, 8'h5A, 4'h7, w);
    in_valid = 1'b0;
    wait_out("post_rst", model(8'hC3, 8'h5A), 4'h7);
    repeat (3) step();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
